// File: rtl/abcd_sequencer.sv
// abcd_sequencer: registered A..D code source sweeping all 16 codes under valid/ready.
// Define GRAY_ORDER_EN to emit the codes in reflected Gray order instead of binary.
module abcd_sequencer #(
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic Clock,
  input  logic Reset_b,
  input  logic start,
  input  logic stop,
  input  logic ready,
  output logic A,
  output logic B,
  output logic C,
  output logic D,
  output logic valid,
  output logic last,
  output logic busy,
  output logic done
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP,
    DONE
  } state_t;

  localparam logic [3:0] GAP_LD  = 4'(GAP_CYCLES);
  localparam bit         HAS_GAP = (GAP_CYCLES != 0);
  localparam logic [3:0] IDX_MAX = 4'd15;

  state_t     state_q;
  state_t     state_d;
  logic [3:0] idx_q;
  logic [3:0] idx_d;
  logic [3:0] gap_q;
  logic [3:0] gap_d;
  logic [3:0] code_q;
  logic [3:0] code_d;
  logic       valid_d;
  logic       last_d;
  logic       busy_d;
  logic       done_d;
  logic       hs;
  logic [3:0] idx_nx;

  function automatic logic [3:0] map_code(
    input logic [3:0] i
  );
`ifdef GRAY_ORDER_EN
    return i ^ (i >> 1);
`else
    return i;
`endif
  endfunction

  assign hs     = valid && ready;
  assign idx_nx = idx_q + 4'd1;

  assign {A, B, C, D} = code_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    code_d  = code_q;
    valid_d = valid;
    last_d  = last;
    busy_d  = busy;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SEND;
          idx_d   = 4'd0;
          gap_d   = 4'd0;
          code_d  = map_code(4'd0);
          valid_d = 1'b1;
          last_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      SEND: begin
        // stop outranks a same-cycle handshake
        if (stop) begin
          state_d = IDLE;
          gap_d   = 4'd0;
          valid_d = 1'b0;
          last_d  = 1'b0;
          busy_d  = 1'b0;
        end else if (hs) begin
          if (idx_q == IDX_MAX) begin
            state_d = DONE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (HAS_GAP) begin
            state_d = GAP;
            gap_d   = GAP_LD;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            idx_d  = idx_nx;
            code_d = map_code(idx_nx);
            last_d = (idx_nx == IDX_MAX);
          end
        end
      end
      GAP: begin
        if (stop) begin
          state_d = IDLE;
          gap_d   = 4'd0;
          valid_d = 1'b0;
          last_d  = 1'b0;
          busy_d  = 1'b0;
        end else if (gap_q == 4'd1) begin
          state_d = SEND;
          gap_d   = 4'd0;
          idx_d   = idx_nx;
          code_d  = map_code(idx_nx);
          valid_d = 1'b1;
          last_d  = (idx_nx == IDX_MAX);
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      gap_q   <= 4'd0;
      code_q  <= 4'd0;
      valid   <= 1'b0;
      last    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      code_q  <= code_d;
      valid   <= valid_d;
      last    <= last_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  a_last_valid: assert property (
    @(posedge Clock) disable iff (!Reset_b)
    last |-> valid
  );

  a_valid_busy: assert property (
    @(posedge Clock) disable iff (!Reset_b)
    valid |-> busy
  );

  a_done_idle: assert property (
    @(posedge Clock) disable iff (!Reset_b)
    done |-> !busy && !valid
  );

endmodule
